pipe_elastic_stage: RTL

PIPE_ELASTIC_STAGE -- requirements
Module: pipe_elastic_stage

---
 rtl/pipe_pkg.sv | 9 +
 rtl/stage_payload_reg.sv | 27 ++
 rtl/pipe_elastic_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for the elastic pipeline stage.
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 3;
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  function automatic logic [1:0] occ_of(input state_t s);
    return s;
  endfunction
endpackage

// File: rtl/stage_payload_reg.sv
// stage_payload_reg: load-enabled data+ctrl register, async reset, sync ctrl clear.
module stage_payload_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q_data <= '0;
      q_ctrl <= '0;
    end else begin
      if (load) q_data <= d_data;
      if (clear) q_ctrl <= '0;
      else if (load) q_ctrl <= d_ctrl;
    end
  end
endmodule

// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage: two-entry skid-buffered pipeline register with registered ready and flush.
module pipe_elastic_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        occupancy_o
);
  state_t state, next;
  logic in_fire, out_fire, main_load, skid_load, main_from_skid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= EMPTY;
      in_ready_o <= 1'b0;
    end else begin
      state      <= next;
      in_ready_o <= next != FULL;
    end
  end
  always_comb begin
    next           = state;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin
        next      = BUSY;
        main_load = 1'b1;
      end
      BUSY: begin
        main_load = in_fire & out_fire;
        skid_load = in_fire & ~out_fire;
        next      = skid_load ? FULL : (out_fire & ~in_fire) ? EMPTY : BUSY;
      end
      FULL: if (out_fire) begin
        next           = BUSY;
        main_load      = 1'b1;
        main_from_skid = 1'b1;
      end
      default: next = EMPTY;
    endcase
    // flush wins: drop any concurrent accept, a concurrent delivery already happened
    if (flush_i) begin
      next      = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end
  stage_payload_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load   (main_load),
    .clear  (flush_i),
    .d_data (main_from_skid ? skid_data : data_i),
    .d_ctrl (main_from_skid ? skid_ctrl : ctrl_i),
    .q_data (main_data),
    .q_ctrl (main_ctrl)
  );
  stage_payload_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load   (skid_load),
    .clear  (flush_i),
    .d_data (data_i),
    .d_ctrl (ctrl_i),
    .q_data (skid_data),
    .q_ctrl (skid_ctrl)
  );
  assign out_valid_o = state != EMPTY;
  assign occupancy_o = occ_of(state);
  assign data_o      = main_data;
  assign ctrl_o      = out_valid_o ? main_ctrl : '0;
endmodule
